debug_step_controller: RTL and testbench

Host-side command sequencer for the single-step debugger. It takes decoded host endpoint values (wire-ins and trigger pulses) and generates the `single_step` level that the debug unit synchronizes and edge-detects into gated `sys_clk` edges. It supports single steps, bursts of N steps with a programmable gap, abort, and a breakpoint on the debug unit's `clock_counter`. Run status is reported back for host wire-outs.

---
 rtl/debug_step_controller.sv | 183 ++++++++++++++++++
 tb/tb_debug_step_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_controller.sv
// rtl/debug_step_controller.sv - host-side single-step / burst sequencer driving the single_step level
// Pulses are 2 cycles high and at least 2 cycles low so the debug unit's two-flop edge detector counts each exactly once.
module debug_step_controller #(
  parameter int COUNT_WIDTH = 16,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   phy_clk,
  input  logic                   reset,
  input  logic                   trig_single,
  input  logic                   trig_run,
  input  logic                   trig_abort,
  input  logic [COUNT_WIDTH-1:0] step_count,
  input  logic [GAP_WIDTH-1:0]   step_gap,
  input  logic                   break_enable,
  input  logic [7:0]             break_value,
  input  logic [7:0]             clock_counter,
  output logic                   single_step,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] steps_done,
  output logic [1:0]             stop_reason
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] REASON_NONE     = 2'b00;
  localparam logic [1:0] REASON_COMPLETE = 2'b01;
  localparam logic [1:0] REASON_BREAK    = 2'b10;
  localparam logic [1:0] REASON_ABORT    = 2'b11;

  localparam logic [GAP_WIDTH-1:0]   GAP_MIN   = GAP_WIDTH'(2);
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = GAP_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remain_q, remain_d;
  logic [COUNT_WIDTH-1:0] steps_q, steps_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   single_step_q, single_step_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             reason_q, reason_d;

  logic [GAP_WIDTH-1:0]   eff_gap;
  logic [COUNT_WIDTH-1:0] steps_inc;
  logic [COUNT_WIDTH-1:0] remain_dec;
  logic                   break_hit;
  logic                   gap_last;
  logic                   start_req;
  logic [COUNT_WIDTH-1:0] start_count;

  assign eff_gap    = (step_gap < GAP_MIN) ? GAP_MIN : step_gap;
  assign steps_inc  = (&steps_q) ? steps_q : steps_q + COUNT_ONE;
  assign remain_dec = (remain_q == '0) ? '0 : remain_q - COUNT_ONE;
  assign break_hit  = break_enable && (clock_counter == break_value);
  assign gap_last   = (cnt_q == gap_q - GAP_ONE);

  // abort outranks both starts; in IDLE it simply suppresses them
  assign start_req   = !trig_abort && (trig_single || trig_run);
  assign start_count = trig_single ? COUNT_ONE : step_count;

  always_comb begin
    state_d       = state_q;
    remain_d      = remain_q;
    steps_d       = steps_q;
    gap_d         = gap_q;
    cnt_d         = cnt_q;
    single_step_d = single_step_q;
    done_d        = done_q;
    reason_d      = reason_q;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          gap_d = eff_gap;
          cnt_d = '0;
          if (start_count == '0) begin
            steps_d  = '0;
            remain_d = '0;
            done_d   = 1'b1;
            reason_d = REASON_COMPLETE;
          end else begin
            // first pulse is counted on the edge that raises single_step
            state_d       = PULSE;
            single_step_d = 1'b1;
            steps_d       = COUNT_ONE;
            remain_d      = start_count - COUNT_ONE;
            done_d        = 1'b0;
            reason_d      = REASON_NONE;
          end
        end
      end

      PULSE: begin
        if (trig_abort) begin
          state_d       = IDLE;
          single_step_d = 1'b0;
          cnt_d         = '0;
          done_d        = 1'b1;
          reason_d      = REASON_ABORT;
        end else if (cnt_q == GAP_ONE) begin
          state_d       = GAP;
          single_step_d = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + GAP_ONE;
        end
      end

      GAP: begin
        if (trig_abort) begin
          state_d       = IDLE;
          single_step_d = 1'b0;
          cnt_d         = '0;
          done_d        = 1'b1;
          reason_d      = REASON_ABORT;
        end else if (gap_last) begin
          cnt_d = '0;
          if (remain_q == '0) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            reason_d = REASON_COMPLETE;
          end else if (break_hit) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            reason_d = REASON_BREAK;
          end else begin
            state_d       = PULSE;
            single_step_d = 1'b1;
            steps_d       = steps_inc;
            remain_d      = remain_dec;
          end
        end else begin
          cnt_d = cnt_q + GAP_ONE;
        end
      end

      default: begin
        state_d       = IDLE;
        single_step_d = 1'b0;
        cnt_d         = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      remain_q      <= '0;
      steps_q       <= '0;
      gap_q         <= GAP_MIN;
      cnt_q         <= '0;
      single_step_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      reason_q      <= REASON_NONE;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      steps_q       <= steps_d;
      gap_q         <= gap_d;
      cnt_q         <= cnt_d;
      single_step_q <= single_step_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      reason_q      <= reason_d;
    end
  end

  assign single_step = single_step_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign steps_done  = steps_q;
  assign stop_reason = reason_q;

endmodule

// File: tb/tb_debug_step_controller.sv
// tb/tb_debug_step_controller.sv - scoreboard bench for debug_step_controller with a debug-unit counter model
module tb_debug_step_controller;
  localparam int CW = 16;
  localparam int GW = 8;

  logic          phy_clk = 1'b0;
  logic          reset = 1'b1;
  logic          trig_single = 1'b0;
  logic          trig_run = 1'b0;
  logic          trig_abort = 1'b0;
  logic [CW-1:0] step_count = '0;
  logic [GW-1:0] step_gap = '0;
  logic          break_enable = 1'b0;
  logic [7:0]    break_value = '0;
  logic [7:0]    clock_counter;
  logic          single_step;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_done;
  logic [1:0]    stop_reason;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 phy_clk = ~phy_clk;

  debug_step_controller #(.COUNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
    .phy_clk(phy_clk), .reset(reset),
    .trig_single(trig_single), .trig_run(trig_run), .trig_abort(trig_abort),
    .step_count(step_count), .step_gap(step_gap),
    .break_enable(break_enable), .break_value(break_value), .clock_counter(clock_counter),
    .single_step(single_step), .busy(busy), .done(done),
    .steps_done(steps_done), .stop_reason(stop_reason)
  );

  // debug unit: two-flop synchronizer plus edge detector feeding its step counter
  logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic [7:0] dbg_cnt = 8'd0;
  logic       dbg_load = 1'b0;
  logic [7:0] dbg_load_val = 8'd0;
  always @(posedge phy_clk) begin
    cyc <= cyc + 1;
    s1  <= single_step;
    s2  <= s1;
    s3  <= s2;
    if (dbg_load) dbg_cnt <= dbg_load_val;
    else if (s2 && !s3) dbg_cnt <= dbg_cnt + 8'd1;
  end
  assign clock_counter = dbg_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int arm;
    int n;
    int g;
    int steps;
    int reason;
    bit abrt;
  } exp_t;
  exp_t q[$];

  // reference: pulse j enters at offset (j-1)*P from the start edge, P = 2+G
  task automatic predict(input int n, input int g, input bit brk, input int bv, input int c0,
                         input int abort_off, output int steps, output int reason);
    int p;
    p = 2 + g;
    if (n == 0) begin
      steps = 0;
      reason = 1;
      return;
    end
    steps = n;
    reason = 1;
    for (int i = 1; i < n; i++) begin
      if (brk && (((c0 + i) % 256) == bv)) begin
        steps = i;
        reason = 2;
        break;
      end
    end
    if (abort_off > 0 && abort_off < steps * p) begin
      steps = (abort_off + p - 1) / p;
      reason = 3;
    end
  endtask

  // monitor
  exp_t cur;
  bit   active = 1'b0;
  int   pulses, hi_len, lo_len, c0;
  logic prev_ss;
  always @(negedge phy_clk) begin
    if (reset) begin
      active = 1'b0;
    end else if (active) begin
      if (busy) begin
        if (single_step && prev_ss) hi_len++;
        else if (single_step) begin
          pulses++;
          chk("gap_low_time", lo_len, cur.g);
          hi_len = 1;
        end else if (prev_ss) begin
          chk("pulse_high_time", hi_len, 2);
          lo_len = 1;
        end else lo_len++;
        prev_ss = single_step;
      end else begin
        chk("pulse_count", pulses, cur.steps);
        chk("steps_done", int'(steps_done), cur.steps);
        chk("stop_reason", int'(stop_reason), cur.reason);
        chk("done_final", int'(done), 1);
        chk("single_step_final", int'(single_step), 0);
        if (!cur.abrt) chk("clock_counter_delta", int'(clock_counter - 8'(c0)), cur.steps % 256);
        active = 1'b0;
      end
    end else if (q.size() > 0 && cyc == q[0].arm + 1) begin
      cur = q.pop_front();
      c0 = int'(clock_counter);
      if (cur.n == 0) begin
        chk("zero_busy", int'(busy), 0);
        chk("zero_single_step", int'(single_step), 0);
        chk("zero_done", int'(done), 1);
        chk("zero_reason", int'(stop_reason), 1);
        chk("zero_steps_done", int'(steps_done), 0);
      end else begin
        chk("start_busy", int'(busy), 1);
        chk("start_single_step", int'(single_step), 1);
        chk("start_done", int'(done), 0);
        chk("start_reason", int'(stop_reason), 0);
        chk("start_steps_done", int'(steps_done), 1);
        active = 1'b1;
        pulses = 1;
        hi_len = 1;
        lo_len = 0;
        prev_ss = 1'b1;
      end
    end
  end

  task automatic load_counter(input int v);
    @(negedge phy_clk);
    dbg_load = 1'b1;
    dbg_load_val = 8'(v);
    @(negedge phy_clk);
    dbg_load = 1'b0;
  endtask

  task automatic run_cmd(input bit sgl, input bit rn, input int n_cnt, input int gap,
                         input bit brk, input int bv, input int abort_off);
    exp_t e;
    int   g_eff, n, st, rs, t;
    g_eff = (gap < 2) ? 2 : gap;
    n = sgl ? 1 : n_cnt;
    predict(n, g_eff, brk, bv, int'(dbg_cnt), abort_off, st, rs);
    @(negedge phy_clk);
    step_count = CW'(n_cnt);
    step_gap = GW'(gap);
    break_enable = brk;
    break_value = 8'(bv);
    trig_single = sgl;
    trig_run = rn;
    e.arm = cyc;
    e.n = n;
    e.g = g_eff;
    e.steps = st;
    e.reason = rs;
    e.abrt = (rs == 3);
    q.push_back(e);
    @(negedge phy_clk);
    trig_single = 1'b0;
    trig_run = 1'b0;
    if (abort_off > 0) begin
      repeat (abort_off - 1) @(negedge phy_clk);
      trig_abort = 1'b1;
      @(negedge phy_clk);
      trig_abort = 1'b0;
    end
    t = 0;
    while (busy && t < 3000) begin
      @(negedge phy_clk);
      t++;
    end
    if (t >= 3000) chk("busy_timeout", 1, 0);
    repeat (5) @(negedge phy_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int kind, n, g, bv, ab, st, rs, g_eff;
    bit brk;
    repeat (3) @(negedge phy_clk);
    chk("reset_single_step", int'(single_step), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_steps_done", int'(steps_done), 0);
    chk("reset_stop_reason", int'(stop_reason), 0);
    reset = 1'b0;
    repeat (5) @(negedge phy_clk);

    run_cmd(1, 0, 0, 0, 0, 0, 0);
    run_cmd(0, 1, 5, 4, 0, 0, 0);
    load_counter(8'h10);
    run_cmd(0, 1, 100, 2, 1, 8'h13, 0);
    chk("break_counter_value", int'(clock_counter), 8'h13);
    run_cmd(0, 1, 10, 3, 0, 0, 3 * 5 + 1);
    run_cmd(1, 1, 7, 2, 0, 0, 0);
    run_cmd(0, 1, 0, 3, 0, 0, 0);
    run_cmd(0, 1, 3, 1, 0, 0, 0);

    // asynchronous reset in the middle of a pulse
    @(negedge phy_clk);
    step_gap = '0;
    trig_single = 1'b1;
    @(negedge phy_clk);
    trig_single = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_single_step", int'(single_step), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_steps_done", int'(steps_done), 0);
    chk("async_stop_reason", int'(stop_reason), 0);
    @(negedge phy_clk);
    reset = 1'b0;
    repeat (5) @(negedge phy_clk);
    run_cmd(1, 0, 0, 3, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 4));
      n = int'($urandom_range(0, 8));
      g = int'($urandom_range(0, 6));
      brk = 1'b0;
      bv = 0;
      ab = 0;
      case (kind)
        0: run_cmd(1, 0, n, g, 0, 0, 0);
        1: run_cmd(0, 1, n, g, 0, 0, 0);
        2: begin
          bv = (int'(dbg_cnt) + int'($urandom_range(1, n + 2))) % 256;
          run_cmd(0, 1, n, g, 1, bv, 0);
        end
        3: begin
          if (n == 0) n = 1;
          g_eff = (g < 2) ? 2 : g;
          predict(n, g_eff, brk, bv, int'(dbg_cnt), 0, st, rs);
          ab = int'($urandom_range(1, st * (2 + g_eff) - 1));
          run_cmd(0, 1, n, g, 0, 0, ab);
        end
        default: run_cmd(1, 1, n, g, 0, 0, 0);
      endcase
    end

    repeat (5) @(negedge phy_clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("monitor_idle", int'(active), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
